operand_bank: RTL and testbench

OPERAND_BANK -- requirements
Module: operand_bank

---
 rtl/operand_bank.sv | 181 ++++++++++++++++++
 tb/tb_operand_bank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bank.sv
// ---------------------------------------------------------------------------
// operand_bank
//   A small bank of NREGS operand registers, each WIDTH bits wide. It is
//   written from a switch bank (sw) under control of three raw push buttons.
//   Each button passes through a 2-flop synchroniser, an optional debounce
//   filter and a rising-edge detector. Every clean press therefore produces
//   exactly one write, no matter how long the button is held.
//
//   Configuration macro: OPERAND_BANK_DEBOUNCE_EN
//     defined   : the filtered level f follows s2 only after s2 has differed
//                 from f for DB_CYCLES consecutive edges. A press is written
//                 DB_CYCLES+3 edges after it rises.
//     undefined : f = s2, no counter exists, DB_CYCLES is ignored. A press is
//                 written 3 edges after it rises.
//   The port list is the same in both builds.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sw           in   WIDTH     load data, sampled on the write edge
//   sel          in   SELW      target register index (user holds it stable)
//   btn_load     in   1         raw button: regs[sel] <= sw
//   btn_clr      in   1         raw button: regs[sel] <= 0
//   btn_clr_all  in   1         raw button: every register <= 0
//   regs         out  NREGS*WIDTH  flat view, regs[i] at [i*WIDTH +: WIDTH]
//   cur          out  WIDTH     regs[sel], or 0 when sel >= NREGS
//   upd          out  1         one-cycle strobe in the cycle after a write
// ---------------------------------------------------------------------------
module operand_bank #(
    parameter int WIDTH     = 4,
    parameter int NREGS     = 2,
    parameter int DB_CYCLES = 16,
    localparam int SELW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       sw,
    input  logic [SELW-1:0]        sel,
    input  logic                   btn_load,
    input  logic                   btn_clr,
    input  logic                   btn_clr_all,
    output logic [NREGS*WIDTH-1:0] regs,
    output logic [WIDTH-1:0]       cur,
    output logic                   upd
);

    // Bit positions of the three buttons inside the per-button vectors.
    localparam int BTN_LOAD    = 0;
    localparam int BTN_CLR     = 1;
    localparam int BTN_CLR_ALL = 2;
    localparam int NBTN        = 3;

    // Elaboration-time range checks on the parameters.
    if (NREGS < 2 || NREGS > 16) begin : g_bad_nregs
        $error("operand_bank: NREGS must be in 2..16");
    end
    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db_cycles
        $error("operand_bank: DB_CYCLES must be in 2..65535");
    end

    logic [NBTN-1:0]  w_btn;
    logic [NBTN-1:0]  r_s1;
    logic [NBTN-1:0]  r_s2;
    logic [NBTN-1:0]  w_f;
    logic [NBTN-1:0]  r_f_d;
    logic [NBTN-1:0]  w_press;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_upd;

    assign w_btn = {btn_clr_all, btn_clr, btn_load};

    // Two-flop synchronisers, one per button.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse s1/s2 into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
        end
    end

`ifdef OPERAND_BANK_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [NBTN-1:0] r_f;
    logic [15:0]     r_cnt [NBTN];

    // The counter runs only while s2 disagrees with f. On the edge where it
    // already holds DB_CYCLES-1, that is the DB_CYCLES-th consecutive
    // disagreeing edge, so f flips and the count restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= '0;
            for (int b = 0; b < NBTN; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBTN; b++) begin
                if (r_s2[b] == r_f[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == DB_LAST) begin
                    r_f[b]   <= ~r_f[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + 16'd1;
                end
            end
        end
    end

    assign w_f = r_f;
`else
    assign w_f = r_s2;
`endif

    // Rising-edge detect on the filtered level: one press per rise of f.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_d <= '0;
        end else begin
            r_f_d <= w_f;
        end
    end

    assign w_press = w_f & ~r_f_d;

    // Register bank write. Clear-all beats clear, and clear beats load, so a
    // load and a clear on the same index leave that register at 0. An index
    // of NREGS or more matches no register, but the write still strobes upd.
    // NOTE: the operand registers sit in the asynchronous reset like every
    // other flop, because the bank must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_upd <= 1'b0;
        end else begin
            r_upd <= |w_press;
            if (w_press[BTN_CLR_ALL]) begin
                for (int i = 0; i < NREGS; i++) begin
                    r_regs[i] <= '0;
                end
            end else if (w_press[BTN_CLR]) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (SELW'(i) == sel) begin
                        r_regs[i] <= '0;
                    end
                end
            end else if (w_press[BTN_LOAD]) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (SELW'(i) == sel) begin
                        r_regs[i] <= sw;
                    end
                end
            end
        end
    end

    // Selected-register read; an out-of-range sel matches nothing and reads 0.
    // NOTE: cur gets its default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cur = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (SELW'(i) == sel) begin
                cur = r_regs[i];
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
        assign regs[gi*WIDTH +: WIDTH] = r_regs[gi];
    end

    assign upd = r_upd;

endmodule

// File: tb/tb_operand_bank.sv
// ---------------------------------------------------------------------------
// tb_operand_bank
//   Directed bench for operand_bank. Instance dut_a (WIDTH=4, NREGS=2) is
//   driven from a table of press records. Each record holds the buttons, sel,
//   sw and the register image expected afterwards. Hand-written sequences
//   cover clear-all held under a later load, reset during a pending press,
//   a button held through reset release and, in the debounced build, a
//   bouncing button. Instance dut_b (WIDTH=8, NREGS=3) covers out-of-range
//   sel. Press latency is 3 edges, or DB_CYCLES+3 when
//   OPERAND_BANK_DEBOUNCE_EN is defined.
// ---------------------------------------------------------------------------
module tb_operand_bank;

    localparam int DB = 4;
`ifdef OPERAND_BANK_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut_a: WIDTH=4, NREGS=2
    logic [3:0] a_sw = '0;
    logic       a_sel = '0;
    logic       a_load = 1'b0, a_clr = 1'b0, a_ca = 1'b0;
    logic [7:0] a_regs;
    logic [3:0] a_cur;
    logic       a_upd;

    // dut_b: WIDTH=8, NREGS=3
    logic [7:0]  b_sw = '0;
    logic [1:0]  b_sel = '0;
    logic        b_load = 1'b0, b_clr = 1'b0, b_ca = 1'b0;
    logic [23:0] b_regs;
    logic [7:0]  b_cur;
    logic        b_upd;

    operand_bank #(.WIDTH(4), .NREGS(2), .DB_CYCLES(DB)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw(a_sw), .sel(a_sel),
        .btn_load(a_load), .btn_clr(a_clr), .btn_clr_all(a_ca),
        .regs(a_regs), .cur(a_cur), .upd(a_upd)
    );

    operand_bank #(.WIDTH(8), .NREGS(3), .DB_CYCLES(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw(b_sw), .sel(b_sel),
        .btn_load(b_load), .btn_clr(b_clr), .btn_clr_all(b_ca),
        .regs(b_regs), .cur(b_cur), .upd(b_upd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       ld;
        logic       cl;
        logic       ca;
        logic       sel;
        logic [3:0] sw;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // Counts upd pulses over n edges, sampled 1 time unit after each edge, and
    // records the first edge (1-based) on which upd was seen.
    int n_upd;
    int first_upd;
    task automatic watch_a(input int n);
        n_upd = 0;
        first_upd = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (a_upd) begin
                n_upd++;
                if (first_upd == 0) first_upd = k;
            end
        end
    endtask

    task automatic watch_b(input int n);
        n_upd = 0;
        first_upd = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (b_upd) begin
                n_upd++;
                if (first_upd == 0) first_upd = k;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v, input logic [7:0] prev);
        logic [7:0] pre;
        logic [3:0] exp_cur;
        @(negedge clk);
        a_sel  = v.sel;
        a_sw   = v.sw;
        a_load = v.ld;
        a_clr  = v.cl;
        a_ca   = v.ca;
        n_upd = 0;
        first_upd = 0;
        pre = '0;
        for (int k = 1; k <= LAT + 6; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT - 1) pre = a_regs;
            if (a_upd) begin
                n_upd++;
                if (first_upd == 0) first_upd = k;
            end
        end
        check($sformatf("vec%0d regs before write edge", idx), 32'(pre), 32'(prev));
        check($sformatf("vec%0d write edge", idx), 32'(first_upd), 32'(LAT));
        exp_cur = v.sel ? v.exp[7:4] : v.exp[3:0];
        check($sformatf("vec%0d regs", idx), 32'(a_regs), 32'(v.exp));
        check($sformatf("vec%0d cur", idx), 32'(a_cur), 32'(exp_cur));
        // Release: the falling edge must not write again.
        @(negedge clk);
        a_load = 1'b0;
        a_clr  = 1'b0;
        a_ca   = 1'b0;
        begin
            int held_upd;
            held_upd = n_upd;
            watch_a(LAT + 4);
            check($sformatf("vec%0d upd pulses", idx), 32'(held_upd + n_upd), 32'd1);
        end
    endtask

    task automatic press_b(input string name, input logic [1:0] sel,
                           input logic [7:0] sw, input logic [23:0] exp_regs,
                           input logic [7:0] exp_cur);
        int total;
        @(negedge clk);
        b_sel  = sel;
        b_sw   = sw;
        b_load = 1'b1;
        watch_b(LAT + 4);
        check({name, " write edge"}, 32'(first_upd), 32'(LAT));
        check({name, " regs"}, 32'(b_regs), 32'(exp_regs));
        check({name, " cur"}, 32'(b_cur), 32'(exp_cur));
        total = n_upd;
        @(negedge clk);
        b_load = 1'b0;
        watch_b(LAT + 4);
        check({name, " upd pulses"}, 32'(total + n_upd), 32'd1);
    endtask

    initial begin
        // ld cl ca sel sw     expected {regs[1],regs[0]}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 8'hA0}; // load into regs[1]
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 8'hA3};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 8'h53};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h50}; // load+clr -> 0
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 8'h57};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 8'h07}; // clr regs[1]
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 8'hC7};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 8'h00}; // clr_all beats load
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'h01};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 8'h21};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 8'h20};

        // Reset state, reached without any clock edge.
        #1;
        check("reset a_regs", 32'(a_regs), 32'h0);
        check("reset a_upd", 32'(a_upd), 32'h0);
        check("reset a_cur", 32'(a_cur), 32'h0);
        check("reset b_regs", 32'(b_regs), 32'h0);
        check("reset b_upd", 32'(b_upd), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven presses on dut_a.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i], (i == 0) ? 8'h00 : vecs[i-1].exp);
        end

        // Clear-all held, then a load pressed later still writes once.
        @(negedge clk);
        a_ca = 1'b1;
        watch_a(LAT + 3);
        check("clr_all held regs", 32'(a_regs), 32'h0);
        check("clr_all held upd pulses", 32'(n_upd), 32'd1);
        @(negedge clk);
        a_sel  = 1'b0;
        a_sw   = 4'h6;
        a_load = 1'b1;
        watch_a(LAT + 6);
        check("load under clr_all write edge", 32'(first_upd), 32'(LAT));
        check("load under clr_all upd pulses", 32'(n_upd), 32'd1);
        check("load under clr_all regs", 32'(a_regs), 32'h06);
        @(negedge clk);
        a_load = 1'b0;
        a_ca   = 1'b0;
        watch_a(LAT + 4);
        check("release after clr_all upd pulses", 32'(n_upd), 32'd0);

        // Button held through reset release counts as a new press.
        @(negedge clk);
        a_sel  = 1'b1;
        a_sw   = 4'h4;
        a_load = 1'b1;
        rst_n  = 1'b0;
        #1;
        check("async reset clears regs", 32'(a_regs), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_a(LAT + 4);
        check("held through reset write edge", 32'(first_upd), 32'(LAT));
        check("held through reset upd pulses", 32'(n_upd), 32'd1);
        check("held through reset regs", 32'(a_regs), 32'h40);
        @(negedge clk);
        a_load = 1'b0;
        watch_a(LAT + 4);

        // Reset two edges after a press rises discards it.
        @(negedge clk);
        a_sel  = 1'b0;
        a_sw   = 4'hF;
        a_load = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-press reset regs", 32'(a_regs), 32'h0);
        check("mid-press reset upd", 32'(a_upd), 32'h0);
        @(negedge clk);
        a_load = 1'b0;
        rst_n  = 1'b1;
        watch_a(LAT + 6);
        check("discarded press upd pulses", 32'(n_upd), 32'd0);
        check("discarded press regs", 32'(a_regs), 32'h0);

`ifdef OPERAND_BANK_DEBOUNCE_EN
        // Bouncing button: no write while toggling, one write once stable.
        @(negedge clk);
        a_sel = 1'b1;
        a_sw  = 4'h3;
        n_upd = 0;
        begin
            int bounce_upd;
            bounce_upd = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                a_load = ~a_load;
                #1;
                if (a_upd) bounce_upd++;
            end
            check("bounce upd pulses", 32'(bounce_upd), 32'd0);
        end
        @(negedge clk);
        a_load = 1'b1;
        watch_a(LAT + 4);
        check("debounced write edge", 32'(first_upd), 32'(DB + 3));
        check("debounced upd pulses", 32'(n_upd), 32'd1);
        check("debounced regs", 32'(a_regs), 32'h30);
        @(negedge clk);
        a_load = 1'b0;
        watch_a(LAT + 4);
`endif

        // dut_b: in-range load, then out-of-range sel.
        press_b("b sel2 load", 2'd2, 8'h5A, 24'h5A0000, 8'h5A);
        press_b("b sel1 load", 2'd1, 8'h3C, 24'h5A3C00, 8'h3C);
        press_b("b sel3 load", 2'd3, 8'hFF, 24'h5A3C00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
